// File: rtl/spi_frame_rx_pkg.sv
// Shared constants and types for the SPI frame receiver.
// Latency: none (declarations only).
// Backpressure: n/a.
package spi_frame_rx_pkg;

  // CRC-16/CCITT: poly 0x1021, seeded with all ones, MSB first, no final XOR
  localparam logic [15:0] CRC_POLY       = 16'h1021;
  localparam logic [15:0] CRC_INIT       = 16'hFFFF;

  // Default two-byte frame sync word, sent MSB first
  localparam logic [15:0] DEFAULT_HEADER = 16'hEB90;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_e;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Bundle of SPI line inputs, consumer acknowledge and frame outputs.
// Latency: none (wiring only).
// Backpressure: consumer holds load high to acknowledge; ready drops next clk.
interface spi_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 40
);
  logic                       spi_sclk;
  logic                       spi_din;
  logic                       load;
  logic                       ready;
  logic [8*PAYLOAD_BYTES-1:0] frame_data;
  logic                       crc_err;
  logic                       overrun;

  // Stimulus/consumer side
  modport master (
    output spi_sclk, spi_din, load,
    input  ready, frame_data, crc_err, overrun
  );

  // Receiver side
  modport slave (
    input  spi_sclk, spi_din, load,
    output ready, frame_data, crc_err, overrun
  );
endinterface

// File: rtl/spi_frame_rx_crc16_ccitt_byte.sv
// One-byte CRC-16/CCITT update, MSB first (exists only when SPI_FRAME_RX_CRC_EN is defined).
// Latency: purely combinational.
// Backpressure: none.
`ifdef SPI_FRAME_RX_CRC_EN
module crc16_ccitt_byte
  import spi_frame_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Eight serial LFSR steps, data bit 7 first
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule
`endif

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: header hunt, payload capture, optional CRC check (SPI_FRAME_RX_CRC_EN).
// Latency: ready/crc_err/overrun 2 clk after the internal strobe of the last CRC bit.
// Backpressure: none on SPI; a good frame arriving while a frame is unconsumed is dropped with overrun.
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int          PAYLOAD_BYTES  = 40,
  parameter logic [15:0] HEADER         = DEFAULT_HEADER,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst,
  spi_frame_rx_if.slave bus
);

  localparam int FW  = 8 * PAYLOAD_BYTES;
  localparam int BCW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic rst_meta_q, rst_n_q;

  // Reset asserts asynchronously, releases on clk through two flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic [2:0] sclk_q;
  logic [1:0] din_q;
  logic       strobe;
  logic       din_s;

  // Two-flop synchronizers; the third sclk flop feeds the rising-edge detect
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      sclk_q <= '0;
      din_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      din_q  <= {din_q[0], bus.spi_din};
    end
  end

  assign strobe = sclk_q[1] & ~sclk_q[2];
  assign din_s  = din_q[1];

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [14:0]       window_q, window_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              fin_q, fin_d;
  logic [7:0]        rx_byte;
  logic [15:0]       rx_win;
  logic              byte_done;
  logic              frame_ok;

  assign rx_byte   = {shift_q, din_s};
  assign rx_win    = {window_q, din_s};
  assign byte_done = strobe && (bit_cnt_q == 3'd7);

`ifdef SPI_FRAME_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic [7:0]  crc_hi_q, crc_hi_d;
  logic        match_q, match_d;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc_q),
    .data    (rx_byte),
    .crc_out (crc_next)
  );

  assign frame_ok = match_q;

  // CRC accumulator, received CRC high byte and registered compare result
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      crc_q    <= CRC_INIT;
      crc_hi_q <= '0;
      match_q  <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_hi_q <= crc_hi_d;
      match_q  <= match_d;
    end
  end
`else
  // CRC bytes are consumed but not checked; every complete frame is good
  assign frame_ok = 1'b1;
`endif

  // Receive state and datapath registers
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      window_q   <= '0;
      shadow_q   <= '0;
      to_cnt_q   <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      window_q   <= window_d;
      shadow_q   <= shadow_d;
      to_cnt_q   <= to_cnt_d;
      fin_q      <= fin_d;
    end
  end

  // Next state: shift on strobe, hunt/payload/CRC sequencing, idle timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    window_d   = window_q;
    shadow_d   = shadow_q;
    to_cnt_d   = to_cnt_q;
    fin_d      = 1'b0;
`ifdef SPI_FRAME_RX_CRC_EN
    crc_d      = crc_q;
    crc_hi_d   = crc_hi_q;
    match_d    = 1'b0;
`endif
    if (strobe) begin
      // A strobe always wins over a coinciding timeout and reloads the counter
      shift_d   = rx_byte[6:0];
      window_d  = rx_win[14:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      to_cnt_d  = '0;
      case (state_q)
        ST_HUNT: begin
          if (rx_win == HEADER) begin
            state_d    = ST_PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
`ifdef SPI_FRAME_RX_CRC_EN
            crc_d      = CRC_INIT;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (byte_done) begin
            // Shifting in from the bottom leaves byte 0 in the MSBs at the end
            shadow_d      = shadow_q << 8;
            shadow_d[7:0] = rx_byte;
`ifdef SPI_FRAME_RX_CRC_EN
            crc_d         = crc_next;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
              state_d    = ST_CRC;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
        end
        ST_CRC: begin
          if (byte_done) begin
            if (byte_cnt_q == '0) begin
              byte_cnt_d = BCW'(1);
`ifdef SPI_FRAME_RX_CRC_EN
              crc_hi_d   = rx_byte;
`endif
            end else begin
              fin_d      = 1'b1;
`ifdef SPI_FRAME_RX_CRC_EN
              match_d    = ({crc_hi_q, rx_byte} == crc_q);
`endif
              state_d    = ST_HUNT;
              byte_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT) begin
      if (to_cnt_q == TO_LAST) begin
        // Idle too long mid-frame: drop it silently and resync
        state_d    = ST_HUNT;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        shift_d    = '0;
        window_d   = '0;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  logic          ready_q, ready_d;
  logic          pend_q, pend_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          overrun_q, overrun_d;
  logic          busy, accept;

  // A frame latched while load is still high waits in pend until load drops
  assign busy   = ready_q | pend_q;
  assign accept = fin_q & frame_ok & ~busy;

  // Output stage: latch, handshake and status pulses
  always_comb begin
    frame_d   = accept ? shadow_q : frame_q;
    overrun_d = fin_q & frame_ok & busy;
    ready_d   = bus.load ? 1'b0 : (ready_q | pend_q | accept);
    pend_d    = bus.load ? (pend_q | accept) : 1'b0;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      ready_q   <= 1'b0;
      pend_q    <= 1'b0;
      frame_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SPI_FRAME_RX_CRC_EN
  logic crc_err_q;

  // CRC mismatch pulse, aligned with where ready would have risen
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= fin_q & ~frame_ok;
    end
  end

  assign bus.crc_err = crc_err_q;
`else
  assign bus.crc_err = 1'b0;
`endif

  assign bus.ready      = ready_q;
  assign bus.frame_data = frame_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: frame table plus hand-written corner sequences.
// Expectations adapt to whether SPI_FRAME_RX_CRC_EN is defined.
module tb_spi_frame_rx;

  localparam int P = 40;
  localparam int W = 8 * P;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_frame_rx_if #(.PAYLOAD_BYTES(P)) bus ();

  spi_frame_rx #(
    .PAYLOAD_BYTES  (P),
    .HEADER         (16'hEB90),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise = 0;
  int cerr_cnt = 0;
  int ovr_cnt  = 0;
  logic ready_prev = 1'b0;
  logic [W-1:0] sb_q[$];
  logic [7:0] pl [P];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: each ready rise pops one expected frame
  always @(negedge clk) begin
    if (bus.crc_err === 1'b1) cerr_cnt++;
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: ready rose at cycle %0d, no frame expected", cyc);
      end else begin
        check("frame_data_at_ready", bus.frame_data, sb_q.pop_front());
        check("ready_latency", W'(cyc - last_rise), W'(4));
      end
    end
    ready_prev = bus.ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.spi_din  = b;
    bus.spi_sclk = 1'b0;
    tick(4);
    bus.spi_sclk = 1'b1;
    last_rise    = cyc;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  function automatic logic [15:0] crc_of_pl();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < P; i++) begin
      c = c ^ {pl[i], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic void fill(input logic [7:0] base);
    for (int i = 0; i < P; i++) pl[i] = base + 8'(i);
  endfunction

  function automatic logic [W-1:0] pl_vec();
    logic [W-1:0] v;
    for (int i = 0; i < P; i++) v[W-1-8*i -: 8] = pl[i];
    return v;
  endfunction

  function automatic logic [W-1:0] base_vec(input logic [7:0] base);
    logic [W-1:0] v;
    for (int i = 0; i < P; i++) v[W-1-8*i -: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic send_frame(input logic [15:0] cx);
    logic [15:0] c;
    c = crc_of_pl() ^ cx;
    send_byte(8'hEB);
    send_byte(8'h90);
    for (int i = 0; i < P; i++) send_byte(pl[i]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic ack_if_ready();
    if (bus.ready === 1'b1) begin
      bus.load = 1'b1;
      tick(1);
      bus.load = 1'b0;
    end
  endtask

  typedef struct {
    bit          ack;
    logic [7:0]  base;
    logic [15:0] cx;
    bit          e_ready;
    bit          e_rise;
    int          e_cerr;
    int          e_ovr;
    logic [7:0]  e_dbase;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int c0, o0;

    // ack, base, crc xor, ready, rise, crc_err, overrun, frame_data base
    tbl[0] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 0, 0, 8'h00};
    tbl[1] = '{1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 0, 1, 8'h00};
    tbl[2] = '{1'b1, 8'h80, 16'h0000, 1'b1, 1'b1, 0, 0, 8'h80};
`ifdef SPI_FRAME_RX_CRC_EN
    tbl[3] = '{1'b1, 8'h00, 16'h0001, 1'b0, 1'b0, 1, 0, 8'h80};
    tbl[4] = '{1'b0, 8'hC0, 16'h0000, 1'b1, 1'b1, 0, 0, 8'hC0};
    tbl[5] = '{1'b1, 8'h10, 16'h0100, 1'b0, 1'b0, 1, 0, 8'hC0};
`else
    tbl[3] = '{1'b1, 8'h00, 16'h0001, 1'b1, 1'b1, 0, 0, 8'h00};
    tbl[4] = '{1'b0, 8'hC0, 16'h0000, 1'b1, 1'b0, 0, 1, 8'h00};
    tbl[5] = '{1'b1, 8'h10, 16'h0100, 1'b1, 1'b1, 0, 0, 8'h10};
`endif

    bus.spi_sclk = 1'b0;
    bus.spi_din  = 1'b0;
    bus.load     = 1'b0;

    // Reset state
    tick(3);
    check("rst_ready", bus.ready, 0);
    check("rst_crc_err", bus.crc_err, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_frame_data", bus.frame_data, 0);
    rst = 1'b1;
    tick(5);

    // Table-driven frames
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].ack) begin
        check("pre_ack_ready", bus.ready, 1);
        bus.load = 1'b1;
        tick(1);
        check("ack_clears_ready", bus.ready, 0);
        bus.load = 1'b0;
      end
      c0 = cerr_cnt;
      o0 = ovr_cnt;
      fill(tbl[r].base);
      if (tbl[r].e_rise) sb_q.push_back(pl_vec());
      send_frame(tbl[r].cx);
      tick(20);
      check($sformatf("row%0d_ready", r), bus.ready, tbl[r].e_ready);
      check($sformatf("row%0d_crc_err", r), W'(cerr_cnt - c0), W'(tbl[r].e_cerr));
      check($sformatf("row%0d_overrun", r), W'(ovr_cnt - o0), W'(tbl[r].e_ovr));
      check($sformatf("row%0d_frame_data", r), bus.frame_data, base_vec(tbl[r].e_dbase));
    end

    // Back-to-back frames: second is hunted straight after the first CRC
    ack_if_ready();
    tick(2);
    c0 = cerr_cnt;
    o0 = ovr_cnt;
    fill(8'h20);
    sb_q.push_back(pl_vec());
    send_frame(16'h0000);
    fill(8'h60);
    send_frame(16'h0000);
    tick(20);
    check("b2b_overrun", W'(ovr_cnt - o0), W'(1));
    check("b2b_frame_data", bus.frame_data, base_vec(8'h20));
    check("b2b_crc_err", W'(cerr_cnt - c0), W'(0));

    // Garbage prefix, and EB 90 inside the payload must not restart the frame
    ack_if_ready();
    tick(2);
    c0 = cerr_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    fill(8'h30);
    pl[5] = 8'hEB;
    pl[6] = 8'h90;
    sb_q.push_back(pl_vec());
    send_frame(16'h0000);
    tick(20);
    check("falsehdr_ready", bus.ready, 1);
    check("falsehdr_crc_err", W'(cerr_cnt - c0), W'(0));

    // Timeout resync: 10 payload bytes, long idle, then a full frame
    ack_if_ready();
    tick(2);
    c0 = cerr_cnt;
    o0 = ovr_cnt;
    send_byte(8'hEB);
    send_byte(8'h90);
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    tick(1010);
    fill(8'h50);
    sb_q.push_back(pl_vec());
    send_frame(16'h0000);
    tick(20);
    check("timeout_ready", bus.ready, 1);
    check("timeout_frame_data", bus.frame_data, base_vec(8'h50));
    check("timeout_crc_err", W'(cerr_cnt - c0), W'(0));
    check("timeout_overrun", W'(ovr_cnt - o0), W'(0));

    // Reset during byte 20 with a frame still held on the outputs
    send_byte(8'hEB);
    send_byte(8'h90);
    for (int i = 0; i < 20; i++) send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 0);
    check("midrst_frame_data", bus.frame_data, 0);
    check("midrst_crc_err", bus.crc_err, 0);
    check("midrst_overrun", bus.overrun, 0);
    bus.spi_sclk = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(5);
    fill(8'h70);
    sb_q.push_back(pl_vec());
    send_frame(16'h0000);
    tick(20);
    check("postrst_ready", bus.ready, 1);
    check("postrst_frame_data", bus.frame_data, base_vec(8'h70));

    check("scoreboard_empty", W'(sb_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
